krnl_acc_rd_req_gen: RTL and testbench
======================================

KRNL_ACC_RD_REQ_GEN -- requirements
Module: krnl_acc_rd_req_gen

Interface
REQ-001 SHALL have parameter DATA_BYTES, default 64, meaning bytes per AXI read beat (512-bit bus).
REQ-002 SHALL have parameter MAX_BURST, default 16, meaning maximum beats per AR request.
REQ-003 SHALL have port ACLK  in  1  the single clock; all logic on rising edge.
REQ-004 SHALL have port ARESET  in  1  reset, synchronous, active-high.
REQ-005 SHALL have port ap_start  in  1  start request from the control slave.
REQ-006 SHALL have port ap_continue  in  1  one-cycle done-acknowledge from the control slave.
REQ-007 SHALL have port ap_idle  out  1  block idle.
REQ-008 SHALL have port ap_ready  out  1  one-cycle pulse: all read requests issued, new start may be taken.
REQ-009 SHALL have port ap_done  out  1  kernel complete, held until acknowledged.
REQ-010 SHALL have ports ifm_size, wgt_size  in  32 each  transfer sizes in bytes.
REQ-011 SHALL have ports ifm_addr_base, wgt_addr_base  in  64 each  byte base addresses.
REQ-012 SHALL have port core_done  in  1  pulse from compute datapath: all results written.
REQ-013 SHALL have ports m_axi_arvalid out 1, m_axi_arready in 1, m_axi_araddr out 64, m_axi_arlen out 8 (beats-1): AXI4 read-address channel.
REQ-014 SHALL have port req_sel  out  1  qualifies current AR: 0 = IFM, 1 = WGT.

Function
REQ-015 SHALL implement states IDLE, IFM, WGT, WAIT_DONE, DONE.
REQ-016 In IDLE, ap_start=1 SHALL latch both sizes and bases and go to IFM next cycle; ap_start outside IDLE ignored.
REQ-017 Beat count per phase SHALL be ceil(size/DATA_BYTES); base address low log2(DATA_BYTES) bits SHALL be forced to 0.
REQ-018 A phase with zero beats SHALL be skipped with no AR issued (IFM->WGT, WGT->WAIT_DONE in one cycle).
REQ-019 Each AR length SHALL be min(remaining beats, MAX_BURST, beats to next 4 KB boundary); no burst crosses a 4 KB boundary.
REQ-020 m_axi_arvalid, araddr, arlen, req_sel SHALL stay stable while arvalid=1 and arready=0.
REQ-021 On handshake (arvalid&arready) address SHALL advance by (arlen+1)*DATA_BYTES and remaining beats decrement by arlen+1; next AR may be valid the following cycle.
REQ-022 After the last IFM handshake SHALL go to WGT; after last WGT handshake SHALL go to WAIT_DONE and pulse ap_ready for exactly one cycle.
REQ-023 If both sizes are zero, ap_ready SHALL pulse on entry to WAIT_DONE with no AR issued.
REQ-024 In WAIT_DONE, core_done=1 SHALL go to DONE; core_done in any other state SHALL be ignored.
REQ-025 In DONE ap_done SHALL be 1; ap_continue=1 SHALL return to IDLE next cycle; ap_continue elsewhere ignored.
REQ-026 ap_idle SHALL be 1 only in IDLE; all outputs registered except ap_idle/ap_done, decoded from state.
REQ-027 Address arithmetic SHALL be 64-bit with wrap modulo 2^64; beat counters 27-bit minimum.

Reset
REQ-028 ARESET=1 SHALL force IDLE, ap_idle=1, ap_ready=0, ap_done=0, m_axi_arvalid=0, arlen=0, araddr=0, req_sel=0, counters 0.
REQ-029 ARESET mid-burst SHALL drop arvalid next edge regardless of arready; pending handshake abandoned.

Verification
REQ-030 ifm_size=4096, base 0x1000, wgt_size=1024, base 0x8000, arready=1 -> ARs: 0x1000/15, 0x1400/15, 0x1800/15, 0x1C00/15 (req_sel 0), 0x8000/15 (req_sel 1); ap_ready pulse after last.
REQ-031 ifm_size=2048, base 0x0F80 -> ARs 0x0F80/arlen 1, 0x1000/15, 0x1400/13 (4 KB split).
REQ-032 ifm_size=100 -> single AR arlen=1 (ceil 2 beats); wgt_size=0 -> no WGT AR.
REQ-033 arready held 0 for 5 cycles -> arvalid/addr/len/req_sel unchanged throughout, single handshake counted.
REQ-034 core_done before ap_ready ignored; core_done in WAIT_DONE -> ap_done=1 held until ap_continue, then ap_idle=1.
REQ-035 ARESET asserted during IFM with arvalid=1 -> next cycle arvalid=0, ap_idle=1; fresh ap_start restarts from base.

Source files
------------

// File: rtl/krnl_acc_rd_req_gen.sv
// AXI4 read-request generator for the accelerator kernel: issues IFM then WGT bursts,
// splitting at MAX_BURST and 4 KB boundaries, and runs the ap_* start/ready/done handshake.
module krnl_acc_rd_req_gen #(
  parameter int DATA_BYTES = 64,
  parameter int MAX_BURST  = 16
) (
  input  logic        ACLK,
  input  logic        ARESET,
  input  logic        ap_start,
  input  logic        ap_continue,
  output logic        ap_idle,
  output logic        ap_ready,
  output logic        ap_done,
  input  logic [31:0] ifm_size,
  input  logic [31:0] wgt_size,
  input  logic [63:0] ifm_addr_base,
  input  logic [63:0] wgt_addr_base,
  input  logic        core_done,
  output logic        m_axi_arvalid,
  input  logic        m_axi_arready,
  output logic [63:0] m_axi_araddr,
  output logic [7:0]  m_axi_arlen,
  output logic        req_sel
);

  localparam int          OFF       = $clog2(DATA_BYTES);
  localparam logic [63:0] ADDR_MASK = ~64'(DATA_BYTES - 1);
  localparam logic [31:0] SIZE_MASK = 32'(DATA_BYTES - 1);

  // IDLE: wait start | IFM/WGT: issue that phase's ARs | WAIT_DONE: wait core | DONE: wait ack
  typedef enum logic [2:0] {S_IDLE, S_IFM, S_WGT, S_WAIT_DONE, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [63:0] ifm_addr_q, ifm_addr_d, wgt_addr_q, wgt_addr_d;
  logic [31:0] ifm_beats_q, ifm_beats_d, wgt_beats_q, wgt_beats_d;
  logic        arvalid_q, arvalid_d;
  logic [63:0] araddr_q, araddr_d;
  logic [7:0]  arlen_q, arlen_d;
  logic        req_sel_q, req_sel_d;
  logic        ap_ready_q, ap_ready_d;

  logic        hs;
  logic [31:0] step;
  logic [63:0] cur_addr, src_addr;
  logic [31:0] cur_beats, src_beats;
  logic [12:0] room_bytes;
  logic [31:0] room, burst;

  function automatic logic [31:0] beats_of(input logic [31:0] size);
    return (size >> OFF) + 32'((size & SIZE_MASK) != 32'd0);
  endfunction

  // src_* is the phase position after any handshake this cycle; next burst is cut from it.
  always_comb begin
    hs         = arvalid_q & m_axi_arready;
    step       = 32'(arlen_q) + 32'd1;
    cur_addr   = (state_q == S_WGT) ? wgt_addr_q : ifm_addr_q;
    cur_beats  = (state_q == S_WGT) ? wgt_beats_q : ifm_beats_q;
    src_addr   = hs ? cur_addr + (64'(step) << OFF) : cur_addr;
    src_beats  = hs ? cur_beats - step : cur_beats;
    room_bytes = 13'h1000 - {1'b0, src_addr[11:0]};
    room       = 32'(room_bytes) >> OFF;
    burst      = src_beats;
    if (burst > 32'(MAX_BURST)) burst = 32'(MAX_BURST);
    if (burst > room)           burst = room;
  end

  always_comb begin
    state_d     = state_q;
    ifm_addr_d  = ifm_addr_q;
    wgt_addr_d  = wgt_addr_q;
    ifm_beats_d = ifm_beats_q;
    wgt_beats_d = wgt_beats_q;
    arvalid_d   = arvalid_q;
    araddr_d    = araddr_q;
    arlen_d     = arlen_q;
    req_sel_d   = req_sel_q;
    ap_ready_d  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (ap_start) begin
          ifm_addr_d  = ifm_addr_base & ADDR_MASK;
          wgt_addr_d  = wgt_addr_base & ADDR_MASK;
          ifm_beats_d = beats_of(ifm_size);
          wgt_beats_d = beats_of(wgt_size);
          state_d     = S_IFM;
        end
      end
      S_IFM, S_WGT: begin
        if (state_q == S_IFM) begin
          ifm_addr_d  = src_addr;
          ifm_beats_d = src_beats;
        end else begin
          wgt_addr_d  = src_addr;
          wgt_beats_d = src_beats;
        end
        if (!arvalid_q || hs) begin
          if (src_beats == 32'd0) begin
            arvalid_d = 1'b0;
            if (state_q == S_IFM) begin
              state_d = S_WGT;
            end else begin
              state_d    = S_WAIT_DONE;
              ap_ready_d = 1'b1;
            end
          end else begin
            arvalid_d = 1'b1;
            araddr_d  = src_addr;
            arlen_d   = 8'(burst - 32'd1);
            req_sel_d = (state_q == S_WGT);
          end
        end
      end
      S_WAIT_DONE: if (core_done) state_d = S_DONE;
      S_DONE:      if (ap_continue) state_d = S_IDLE;
      default:     state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      state_q     <= S_IDLE;
      ifm_addr_q  <= '0;
      wgt_addr_q  <= '0;
      ifm_beats_q <= '0;
      wgt_beats_q <= '0;
      arvalid_q   <= 1'b0;
      araddr_q    <= '0;
      arlen_q     <= '0;
      req_sel_q   <= 1'b0;
      ap_ready_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      ifm_addr_q  <= ifm_addr_d;
      wgt_addr_q  <= wgt_addr_d;
      ifm_beats_q <= ifm_beats_d;
      wgt_beats_q <= wgt_beats_d;
      arvalid_q   <= arvalid_d;
      araddr_q    <= araddr_d;
      arlen_q     <= arlen_d;
      req_sel_q   <= req_sel_d;
      ap_ready_q  <= ap_ready_d;
    end
  end

  assign ap_idle       = (state_q == S_IDLE);
  assign ap_done       = (state_q == S_DONE);
  assign ap_ready      = ap_ready_q;
  assign m_axi_arvalid = arvalid_q;
  assign m_axi_araddr  = araddr_q;
  assign m_axi_arlen   = arlen_q;
  assign req_sel       = req_sel_q;

endmodule

// File: tb/tb_krnl_acc_rd_req_gen.sv
// Randomized bench for krnl_acc_rd_req_gen: expected AR sequences come from a burst-splitting
// model built with plain arithmetic; ARs are compared as they handshake.
module tb_krnl_acc_rd_req_gen;
  localparam int DB = 64;
  localparam int MB = 16;

  logic        ACLK = 1'b0;
  logic        ARESET = 1'b1;
  logic        ap_start = 1'b0, ap_continue = 1'b0, core_done = 1'b0;
  logic        ap_idle, ap_ready, ap_done;
  logic [31:0] ifm_size = '0, wgt_size = '0;
  logic [63:0] ifm_addr_base = '0, wgt_addr_base = '0;
  logic        m_axi_arvalid, m_axi_arready = 1'b0, req_sel;
  logic [63:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;

  typedef struct {
    logic [63:0] addr;
    logic [7:0]  len;
    logic        sel;
  } ar_t;

  ar_t exp_q[$];
  int  n_checks = 0;
  int  n_fail = 0;

  krnl_acc_rd_req_gen #(.DATA_BYTES(DB), .MAX_BURST(MB)) dut (
    .ACLK(ACLK), .ARESET(ARESET), .ap_start(ap_start), .ap_continue(ap_continue),
    .ap_idle(ap_idle), .ap_ready(ap_ready), .ap_done(ap_done),
    .ifm_size(ifm_size), .wgt_size(wgt_size),
    .ifm_addr_base(ifm_addr_base), .wgt_addr_base(wgt_addr_base),
    .core_done(core_done), .m_axi_arvalid(m_axi_arvalid), .m_axi_arready(m_axi_arready),
    .m_axi_araddr(m_axi_araddr), .m_axi_arlen(m_axi_arlen), .req_sel(req_sel)
  );

  always #5 ACLK = ~ACLK;

  task automatic tick();
    @(posedge ACLK);
    #1;
  endtask

  // Reference: split ceil(size/DB) beats into bursts limited by MB and the next 4 KB line.
  task automatic build_exp(input logic [31:0] sz, input logic [63:0] base, input logic sel);
    logic [63:0] beats, a, room, n;
    ar_t e;
    beats = ({32'b0, sz} + 64'(DB - 1)) / 64'(DB);
    a     = base & ~64'(DB - 1);
    while (beats != 0) begin
      room = (64'd4096 - (a % 64'd4096)) / 64'(DB);
      n = beats;
      if (n > 64'(MB)) n = 64'(MB);
      if (n > room) n = room;
      e.addr = a; e.len = 8'(n - 1); e.sel = sel;
      exp_q.push_back(e);
      a     = a + n * 64'(DB);
      beats = beats - n;
    end
  endtask

  // mode 0: arready=1, mode 1: random arready, mode 2: first AR stalled 5 cycles
  task automatic run_job(input logic [31:0] isz, input logic [63:0] ib,
                         input logic [31:0] wsz, input logic [63:0] wb,
                         input int mode, input string tag);
    int          stall_left, stalls_seen, exp_n, hold;
    bit          seen_ready, prev_stall;
    logic [63:0] p_addr;
    logic [7:0]  p_len;
    logic        p_sel;
    ar_t         e;
    exp_q.delete();
    build_exp(isz, ib, 1'b0);
    build_exp(wsz, wb, 1'b1);
    exp_n = exp_q.size();
    stall_left = (mode == 2) ? 5 : 0;
    stalls_seen = 0; seen_ready = 0; prev_stall = 0;
    p_addr = '0; p_len = '0; p_sel = 1'b0;
    ifm_size = isz; ifm_addr_base = ib; wgt_size = wsz; wgt_addr_base = wb;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    n_checks++;
    if (ap_idle !== 1'b0) begin
      n_fail++; $display("FAIL %s start_busy: ap_idle=%b required 0", tag, ap_idle);
    end
    core_done = 1'b1;
    for (int cyc = 0; cyc < 3000 && !seen_ready; cyc++) begin
      if (prev_stall) begin
        n_checks++;
        if (!(m_axi_arvalid === 1'b1 && m_axi_araddr === p_addr && m_axi_arlen === p_len &&
              req_sel === p_sel)) begin
          n_fail++;
          $display("FAIL %s stall_stable: v=%b a=%h l=%0d s=%b required v=1 a=%h l=%0d s=%b",
                   tag, m_axi_arvalid, m_axi_araddr, m_axi_arlen, req_sel, p_addr, p_len, p_sel);
        end
      end
      if (ap_ready === 1'b1) begin
        seen_ready = 1;
        n_checks++;
        if (exp_q.size() != 0 || m_axi_arvalid !== 1'b0) begin
          n_fail++;
          $display("FAIL %s ready_early: pending=%0d arvalid=%b required 0/0",
                   tag, exp_q.size(), m_axi_arvalid);
        end
      end
      case (mode)
        0: m_axi_arready = 1'b1;
        1: m_axi_arready = 1'($urandom_range(0, 1));
        default: begin
          if (m_axi_arvalid === 1'b1 && stall_left > 0) begin
            m_axi_arready = 1'b0; stall_left--; stalls_seen++;
          end else m_axi_arready = 1'b1;
        end
      endcase
      if (m_axi_arvalid === 1'b1 && m_axi_arready === 1'b1) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL %s extra_ar: addr=%h len=%0d required none", tag,
                             m_axi_araddr, m_axi_arlen);
        end else begin
          e = exp_q.pop_front();
          if (m_axi_araddr !== e.addr || m_axi_arlen !== e.len || req_sel !== e.sel) begin
            n_fail++;
            $display("FAIL %s ar: addr=%h len=%0d sel=%b required addr=%h len=%0d sel=%b",
                     tag, m_axi_araddr, m_axi_arlen, req_sel, e.addr, e.len, e.sel);
          end
        end
      end
      prev_stall = (m_axi_arvalid === 1'b1) && (m_axi_arready === 1'b0);
      p_addr = m_axi_araddr; p_len = m_axi_arlen; p_sel = req_sel;
      tick();
      core_done = 1'b0;
    end
    m_axi_arready = 1'b0;
    n_checks++;
    if (!seen_ready) begin
      n_fail++; $display("FAIL %s ready_timeout: ap_ready never seen, pending=%0d required 0",
                         tag, exp_q.size());
    end
    n_checks++;
    if (ap_ready !== 1'b0 || ap_done !== 1'b0) begin
      n_fail++; $display("FAIL %s ready_width_or_early_done: ap_ready=%b ap_done=%b required 0/0",
                         tag, ap_ready, ap_done);
    end
    if (mode == 2) begin
      n_checks++;
      if (stalls_seen != (exp_n > 0 ? 5 : 0)) begin
        n_fail++; $display("FAIL %s stall_count: got=%0d required %0d", tag, stalls_seen,
                           exp_n > 0 ? 5 : 0);
      end
    end
    hold = $urandom_range(0, 3);
    for (int i = 0; i < hold; i++) tick();
    n_checks++;
    if (ap_done !== 1'b0 || ap_idle !== 1'b0) begin
      n_fail++; $display("FAIL %s wait_done: ap_done=%b ap_idle=%b required 0/0", tag, ap_done, ap_idle);
    end
    core_done = 1'b1;
    tick();
    core_done = 1'b0;
    hold = $urandom_range(1, 4);
    ap_start = 1'b1;
    for (int i = 0; i < hold; i++) begin
      n_checks++;
      if (ap_done !== 1'b1 || m_axi_arvalid !== 1'b0 || ap_idle !== 1'b0) begin
        n_fail++; $display("FAIL %s done_hold: ap_done=%b arvalid=%b ap_idle=%b required 1/0/0",
                           tag, ap_done, m_axi_arvalid, ap_idle);
      end
      tick();
    end
    ap_start = 1'b0;
    ap_continue = 1'b1;
    tick();
    ap_continue = 1'b0;
    n_checks++;
    if (ap_idle !== 1'b1 || ap_done !== 1'b0) begin
      n_fail++; $display("FAIL %s back_idle: ap_idle=%b ap_done=%b required 1/0", tag, ap_idle, ap_done);
    end
  endtask

  task automatic test_reset();
    ARESET = 1'b1;
    tick(); tick();
    n_checks++;
    if (ap_idle !== 1'b1 || ap_ready !== 1'b0 || ap_done !== 1'b0 || m_axi_arvalid !== 1'b0 ||
        m_axi_arlen !== 8'd0 || m_axi_araddr !== 64'd0 || req_sel !== 1'b0) begin
      n_fail++;
      $display("FAIL reset: idle=%b rdy=%b done=%b v=%b len=%0d a=%h sel=%b required 1/0/0/0/0/0/0",
               ap_idle, ap_ready, ap_done, m_axi_arvalid, m_axi_arlen, m_axi_araddr, req_sel);
    end
    ARESET = 1'b0;
    tick();
  endtask

  task automatic test_directed();
    run_job(32'd4096, 64'h1000, 32'd1024, 64'h8000, 0, "four_plus_one");
    run_job(32'd2048, 64'h0F80, 32'd0, 64'h0, 0, "split_4k");
    run_job(32'd100, 64'h2000, 32'd0, 64'h9000, 0, "partial_beat");
    run_job(32'd0, 64'h3000, 32'd0, 64'h4000, 0, "both_zero");
    run_job(32'd0, 64'h3000, 32'd200, 64'h4FC7, 0, "ifm_zero_unaligned_wgt");
  endtask

  task automatic test_stall();
    run_job(32'd256, 64'h40, 32'd64, 64'h5000, 2, "stall5");
  endtask

  task automatic test_reset_mid_burst();
    bit seen_v;
    seen_v = 0;
    ifm_size = 32'd8192; ifm_addr_base = 64'h2000; wgt_size = 32'd64; wgt_addr_base = 64'h6000;
    m_axi_arready = 1'b0;
    ap_start = 1'b1;
    tick();
    ap_start = 1'b0;
    for (int i = 0; i < 10 && !seen_v; i++) begin
      if (m_axi_arvalid === 1'b1) seen_v = 1;
      else tick();
    end
    n_checks++;
    if (!seen_v) begin
      n_fail++; $display("FAIL midrst_arvalid: arvalid=%b required 1 within 10 cycles", m_axi_arvalid);
    end
    ARESET = 1'b1;
    m_axi_arready = 1'b1;
    tick();
    n_checks++;
    if (m_axi_arvalid !== 1'b0 || ap_idle !== 1'b1 || m_axi_araddr !== 64'd0 || ap_ready !== 1'b0) begin
      n_fail++; $display("FAIL midrst_drop: v=%b idle=%b a=%h rdy=%b required 0/1/0/0",
                         m_axi_arvalid, ap_idle, m_axi_araddr, ap_ready);
    end
    ARESET = 1'b0;
    m_axi_arready = 1'b0;
    tick();
    run_job(32'd8192, 64'h2000, 32'd64, 64'h6000, 0, "restart_after_reset");
  endtask

  task automatic test_random();
    logic [31:0] isz, wsz;
    logic [63:0] ib, wb;
    for (int j = 0; j < 14; j++) begin
      isz = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 3000));
      wsz = ($urandom_range(0, 4) == 0) ? 32'd0 : 32'($urandom_range(1, 3000));
      ib  = {$urandom, $urandom};
      wb  = {$urandom, $urandom};
      if (j % 4 == 1) ib = 64'hFFFF_FFFF_FFFF_F000 + 64'($urandom_range(0, 4095));
      if (j % 4 == 2) wb = {$urandom, 20'h0, 12'($urandom_range(3900, 4095))};
      run_job(isz, ib, wsz, wb, 1, "random");
    end
  endtask

  initial begin
    test_reset();
    test_directed();
    test_stall();
    test_reset_mid_burst();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
